linked_list_buffer: RTL and testbench



---
 rtl/ll_pkg.sv | 20 ++
 rtl/ll_free_list.sv | 45 ++++
 rtl/linked_list_buffer.sv | 111 +++++++++++
 tb/tb_linked_list_buffer.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/ll_pkg.sv
// rtl/ll_pkg.sv - width helpers and shared index/pointer types for linked-list buffers
package ll_pkg;

  // Clamp to one bit so single-entry or single-list builds still elaborate.
  function automatic int ll_clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int ll_cnt_width(input int n);
    return ll_clog2_min1(n) + 1;
  endfunction

  localparam int LL_DEF_ELEMS = 8;
  localparam int LL_DEF_LISTS = 4;

  typedef logic [ll_clog2_min1(LL_DEF_ELEMS)-1:0] ll_ptr_t;
  typedef logic [ll_clog2_min1(LL_DEF_LISTS)-1:0] ll_list_t;
  typedef logic [ll_cnt_width(LL_DEF_ELEMS)-1:0]  ll_cnt_t;

endpackage

// File: rtl/ll_free_list.sv
// rtl/ll_free_list.sv - circular FIFO of unused entry pointers, preloaded 0..NUM_ELEMS-1 on reset
module ll_free_list
  import ll_pkg::*;
#(
  parameter int NUM_ELEMS = 8,
  parameter int PTR_WIDTH = ll_clog2_min1(NUM_ELEMS),
  parameter int CNT_WIDTH = PTR_WIDTH + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 alloc_en,
  output logic [PTR_WIDTH-1:0] alloc_ptr,
  input  logic                 release_en,
  input  logic [PTR_WIDTH-1:0] release_ptr,
  output logic [CNT_WIDTH-1:0] count
);

  logic [PTR_WIDTH-1:0] fifo [NUM_ELEMS];
  logic [PTR_WIDTH-1:0] rd_idx;
  logic [PTR_WIDTH-1:0] wr_idx;

  // Explicit wrap keeps non-power-of-two depths correct.
  function automatic logic [PTR_WIDTH-1:0] wrap_inc(input logic [PTR_WIDTH-1:0] p);
    return (p == PTR_WIDTH'(NUM_ELEMS - 1)) ? '0 : p + PTR_WIDTH'(1);
  endfunction

  assign alloc_ptr = fifo[rd_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_ELEMS; i++) fifo[i] <= PTR_WIDTH'(i);
      rd_idx <= '0;
      wr_idx <= '0;
      count  <= CNT_WIDTH'(NUM_ELEMS);
    end else begin
      if (alloc_en) rd_idx <= wrap_inc(rd_idx);
      if (release_en) begin
        fifo[wr_idx] <= release_ptr;
        wr_idx       <= wrap_inc(wr_idx);
      end
      count <= count + CNT_WIDTH'(release_en) - CNT_WIDTH'(alloc_en);
    end
  end

endmodule

// File: rtl/linked_list_buffer.sv
// rtl/linked_list_buffer.sv - NUM_LISTS FIFOs sharing one entry pool; LL_RESERVE_EN keeps a slot per empty list
module linked_list_buffer
  import ll_pkg::*;
#(
  parameter int NUM_ELEMS  = 8,
  parameter int NUM_LISTS  = 4,
  parameter int DATA_WIDTH = 16,
  localparam int PTR_WIDTH  = ll_clog2_min1(NUM_ELEMS),
  localparam int LIST_WIDTH = ll_clog2_min1(NUM_LISTS),
  localparam int CNT_WIDTH  = PTR_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_en,
  input  logic [LIST_WIDTH-1:0] push_sel,
  input  logic [DATA_WIDTH-1:0] push_data,
  output logic                  push_ack,
  input  logic                  pop_en,
  input  logic [LIST_WIDTH-1:0] pop_sel,
  output logic                  pop_valid,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic [NUM_LISTS-1:0]  empty,
  output logic                  full,
  output logic [CNT_WIDTH-1:0]  free_count
);

  logic [DATA_WIDTH-1:0] data_mem [NUM_ELEMS];
  logic [PTR_WIDTH-1:0]  next_mem [NUM_ELEMS];
  logic [PTR_WIDTH-1:0]  head [NUM_LISTS];
  logic [PTR_WIDTH-1:0]  tail [NUM_LISTS];
  logic [CNT_WIDTH-1:0]  cnt  [NUM_LISTS];

  logic                 pop_ok;
  logic                 push_drains;
  logic [PTR_WIDTH-1:0] alloc_ptr;

  ll_free_list #(
    .NUM_ELEMS(NUM_ELEMS),
    .PTR_WIDTH(PTR_WIDTH),
    .CNT_WIDTH(CNT_WIDTH)
  ) u_free_list (
    .clk        (clk),
    .rst        (rst),
    .alloc_en   (push_ack),
    .alloc_ptr  (alloc_ptr),
    .release_en (pop_ok),
    .release_ptr(head[pop_sel]),
    .count      (free_count)
  );

  always_comb begin
    empty = '0;
    for (int i = 0; i < NUM_LISTS; i++) empty[i] = (cnt[i] == '0);
  end

  assign full   = (free_count == '0);
  assign pop_ok = pop_en & ~empty[pop_sel];

`ifdef LL_RESERVE_EN
  if (NUM_ELEMS < NUM_LISTS) begin : g_reserve_check
    $error("linked_list_buffer: LL_RESERVE_EN needs NUM_ELEMS >= NUM_LISTS");
  end

  int other_empty;
  always_comb begin
    other_empty = 0;
    for (int i = 0; i < NUM_LISTS; i++)
      if (empty[i] && (LIST_WIDTH'(i) != push_sel)) other_empty = other_empty + 1;
    push_ack = push_en & (empty[push_sel] ? ~full : (int'(free_count) > other_empty));
  end
`else
  assign push_ack = push_en & ~full;
`endif

  // The push target is empty once any same-cycle pop has run, so the new entry becomes head.
  assign push_drains = (cnt[push_sel] == '0) ||
                       (pop_ok && (pop_sel == push_sel) && (cnt[push_sel] == CNT_WIDTH'(1)));

  always_ff @(posedge clk) begin
    if (!rst && push_ack) begin
      data_mem[alloc_ptr] <= push_data;
      if (!push_drains) next_mem[tail[push_sel]] <= alloc_ptr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_LISTS; i++) begin
        head[i] <= '0;
        tail[i] <= '0;
        cnt[i]  <= '0;
      end
      pop_valid <= 1'b0;
      pop_data  <= '0;
    end else begin
      pop_valid <= pop_ok;
      if (pop_ok) begin
        pop_data      <= data_mem[head[pop_sel]];
        head[pop_sel] <= next_mem[head[pop_sel]];
      end
      if (push_ack) begin
        tail[push_sel] <= alloc_ptr;
        if (push_drains) head[push_sel] <= alloc_ptr;
      end
      for (int i = 0; i < NUM_LISTS; i++)
        cnt[i] <= cnt[i] + CNT_WIDTH'(push_ack && (push_sel == LIST_WIDTH'(i)))
                         - CNT_WIDTH'(pop_ok && (pop_sel == LIST_WIDTH'(i)));
    end
  end

endmodule

// File: tb/tb_linked_list_buffer.sv
// tb/tb_linked_list_buffer.sv - directed bench for linked_list_buffer (default 8 entries, 4 lists, 16-bit data)
module tb_linked_list_buffer;

  logic        clk;
  logic        rst;
  logic        push_en;
  logic [1:0]  push_sel;
  logic [15:0] push_data;
  logic        push_ack;
  logic        pop_en;
  logic [1:0]  pop_sel;
  logic        pop_valid;
  logic [15:0] pop_data;
  logic [3:0]  empty;
  logic        full;
  logic [3:0]  free_count;

  int   vectors;
  int   miscompares;
  logic ack_seen;

  linked_list_buffer dut (
    .clk       (clk),
    .rst       (rst),
    .push_en   (push_en),
    .push_sel  (push_sel),
    .push_data (push_data),
    .push_ack  (push_ack),
    .pop_en    (pop_en),
    .pop_sel   (pop_sel),
    .pop_valid (pop_valid),
    .pop_data  (pop_data),
    .empty     (empty),
    .full      (full),
    .free_count(free_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, capture push_ack before the edge, return 1ns after the edge.
  task automatic cyc(input logic r, input logic pe, input logic [1:0] ps, input logic [15:0] pd,
                     input logic oe, input logic [1:0] os);
    rst = r; push_en = pe; push_sel = ps; push_data = pd; pop_en = oe; pop_sel = os;
    #1 ack_seen = push_ack;
    @(posedge clk);
    #1;
    rst = 1'b0; push_en = 1'b0; pop_en = 1'b0;
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    rst = 1'b1; push_en = 1'b0; push_sel = '0; push_data = '0; pop_en = 1'b0; pop_sel = '0;
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);

    check("rst_empty", 32'(empty), 32'hF);
    check("rst_full", 32'(full), 0);
    check("rst_free", 32'(free_count), 8);
    check("rst_pop_valid", 32'(pop_valid), 0);
    check("rst_pop_data", 32'(pop_data), 0);

    // Three pushes to list 2, popped back in order.
    cyc(0, 1, 2, 16'hA1, 0, 0);
    check("a1_ack", 32'(ack_seen), 1);
    cyc(0, 1, 2, 16'hA2, 0, 0);
    cyc(0, 1, 2, 16'hA3, 0, 0);
    check("l2_empty", 32'(empty), 32'hB);
    check("l2_free", 32'(free_count), 5);
    cyc(0, 0, 0, 0, 1, 2);
    check("pop_a1_valid", 32'(pop_valid), 1);
    check("pop_a1_data", 32'(pop_data), 32'hA1);
    cyc(0, 0, 0, 0, 1, 2);
    check("pop_a2_data", 32'(pop_data), 32'hA2);
    cyc(0, 0, 0, 0, 1, 2);
    check("pop_a3_data", 32'(pop_data), 32'hA3);
    check("l2_drained", 32'(empty), 32'hF);
    check("l2_free_back", 32'(free_count), 8);
    cyc(0, 0, 0, 0, 0, 0);
    check("idle_valid", 32'(pop_valid), 0);
    check("idle_hold", 32'(pop_data), 32'hA3);

    // Pop of an empty list is ignored.
    cyc(0, 0, 0, 0, 1, 3);
    check("pop_empty_valid", 32'(pop_valid), 0);
    check("pop_empty_free", 32'(free_count), 8);
    check("pop_empty_hold", 32'(pop_data), 32'hA3);

    // Same-list push and pop with count 1.
    cyc(0, 1, 1, 16'h11, 0, 0);
    cyc(0, 1, 1, 16'h22, 1, 1);
    check("swap_ack", 32'(ack_seen), 1);
    check("swap_pop_data", 32'(pop_data), 32'h11);
    check("swap_empty", 32'(empty), 32'hD);
    check("swap_free", 32'(free_count), 7);
    cyc(0, 0, 0, 0, 1, 1);
    check("swap_pop2_data", 32'(pop_data), 32'h22);
    check("swap_empty2", 32'(empty), 32'hF);

    // Fill all eight entries, round-robin over lists.
    for (int k = 0; k < 8; k++) cyc(0, 1, 2'(k), 16'(16'h100 + k), 0, 0);
    check("fill_full", 32'(full), 1);
    check("fill_free", 32'(free_count), 0);
    check("fill_empty", 32'(empty), 0);
    cyc(0, 1, 0, 16'h0BAD, 0, 0);
    check("ninth_ack", 32'(ack_seen), 0);
    cyc(0, 1, 1, 16'h0999, 1, 0);
    check("full_pushpop_ack", 32'(ack_seen), 0);
    check("full_pop_valid", 32'(pop_valid), 1);
    check("full_pop_data", 32'(pop_data), 32'h100);
    check("full_pop_free", 32'(free_count), 1);
    check("full_pop_full", 32'(full), 0);
    cyc(0, 1, 1, 16'h0200, 0, 0);
    check("reuse_ack", 32'(ack_seen), 1);
    check("reuse_free", 32'(free_count), 0);
    cyc(0, 0, 0, 0, 1, 1);
    check("l1_first", 32'(pop_data), 32'h101);
    cyc(0, 0, 0, 0, 1, 1);
    check("l1_second", 32'(pop_data), 32'h105);
    cyc(0, 0, 0, 0, 1, 1);
    check("l1_third", 32'(pop_data), 32'h200);

    // Reset while a pop result is on the output.
    cyc(0, 0, 0, 0, 1, 2);
    check("pre_rst_data", 32'(pop_data), 32'h102);
    check("pre_rst_valid", 32'(pop_valid), 1);
    cyc(1, 1, 3, 16'h77, 1, 0);
    check("mid_rst_valid", 32'(pop_valid), 0);
    check("mid_rst_data", 32'(pop_data), 0);
    check("mid_rst_empty", 32'(empty), 32'hF);
    check("mid_rst_free", 32'(free_count), 8);
    cyc(0, 1, 0, 16'h55, 0, 0);
    cyc(0, 0, 0, 0, 1, 0);
    check("post_rst_data", 32'(pop_data), 32'h55);

`ifdef LL_RESERVE_EN
    // Three other lists empty: list 0 may take entries only while free_count > 3.
    for (int k = 0; k < 5; k++) begin
      cyc(0, 1, 0, 16'(16'h300 + k), 0, 0);
      check("rsv_accept", 32'(ack_seen), 1);
    end
    cyc(0, 1, 0, 16'h3FF, 0, 0);
    check("rsv_refuse", 32'(ack_seen), 0);
    check("rsv_free", 32'(free_count), 3);
    cyc(0, 1, 3, 16'h333, 0, 0);
    check("rsv_l3_ack", 32'(ack_seen), 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
